// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam logic [31:0] BOOT_VECTOR    = 32'hBFC00000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  // Redirect class; numeric order is the priority order.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_BR   = 2'd1,
    CLS_JR   = 2'd2,
    CLS_EXC  = 2'd3
  } redir_cls_e;

  // One arbitrated redirect: class after misalign promotion, target, misalign flag.
  typedef struct packed {
    redir_cls_e        cls;
    logic [ADDR_W-1:0] target;
    logic              misalign;
  } redir_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Request/response bundle between ID/EX hazard logic and the redirect controller.
interface fetch_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             STALL;
  logic             BrValid_IN;
  logic [31:0]      BrTarget_IN;
  logic             JrValid_IN;
  logic [31:0]      JrTarget_IN;
  logic             ExcValid_IN;
  logic [31:0]      AltPC_OUT;
  logic             AltPCEnable_OUT;
  logic             Flush_OUT;
  logic             Pending_OUT;
  logic             Misalign_OUT;
  logic [CNT_W-1:0] RedirectCount_OUT;

  // Requester side: drives stall and redirect requests, observes fetch controls.
  modport master (
    output STALL, BrValid_IN, BrTarget_IN, JrValid_IN, JrTarget_IN, ExcValid_IN,
    input  AltPC_OUT, AltPCEnable_OUT, Flush_OUT, Pending_OUT, Misalign_OUT,
           RedirectCount_OUT
  );

  // Controller side.
  modport slave (
    input  STALL, BrValid_IN, BrTarget_IN, JrValid_IN, JrTarget_IN, ExcValid_IN,
    output AltPC_OUT, AltPCEnable_OUT, Flush_OUT, Pending_OUT, Misalign_OUT,
           RedirectCount_OUT
  );
endinterface

// File: rtl/fetch_redirect_ctrl_prio_sel.sv
// Redirect priority select: EXC > JR > BR, misaligned BR/JR targets promoted to EXC.
module fetch_redirect_ctrl_prio_sel
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        jr_valid_i,
  input  logic [31:0] jr_target_i,
  input  logic        exc_valid_i,
  output redir_t      win_c_o
);

  // Pick the highest-priority request and check target alignment.
  always_comb begin
    win_c_o.cls      = CLS_NONE;
    win_c_o.target   = '0;
    win_c_o.misalign = 1'b0;
    if (exc_valid_i) begin
      win_c_o.cls    = CLS_EXC;
      win_c_o.target = EXC_VECTOR;
    end else if (jr_valid_i) begin
      if (jr_target_i[1:0] != 2'b00) begin
        win_c_o.cls      = CLS_EXC;
        win_c_o.target   = EXC_VECTOR;
        win_c_o.misalign = 1'b1;
      end else begin
        win_c_o.cls    = CLS_JR;
        win_c_o.target = jr_target_i;
      end
    end else if (br_valid_i) begin
      if (br_target_i[1:0] != 2'b00) begin
        win_c_o.cls      = CLS_EXC;
        win_c_o.target   = EXC_VECTOR;
        win_c_o.misalign = 1'b1;
      end else begin
        win_c_o.cls    = CLS_BR;
        win_c_o.target = br_target_i;
      end
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates redirects, holds the winner across stalls,
// and drives the fetch alternate-PC load pulse.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  fetch_redirect_ctrl_if.slave redir_if
);

  redir_t           win_c;
  redir_t           held_q;
  redir_t           issue_sel_c;
  logic             issue_c;
  logic             higher_c;
  state_e           state_q;
  logic [31:0]      altpc_q;
  logic             en_q;
  logic             flush_q;
  logic             pend_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q;

  fetch_redirect_ctrl_prio_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_prio_sel (
    .br_valid_i  (redir_if.BrValid_IN),
    .br_target_i (redir_if.BrTarget_IN),
    .jr_valid_i  (redir_if.JrValid_IN),
    .jr_target_i (redir_if.JrTarget_IN),
    .exc_valid_i (redir_if.ExcValid_IN),
    .win_c_o     (win_c)
  );

  // Decide whether a redirect issues this cycle and which one.
  always_comb begin
    higher_c    = (win_c.cls > held_q.cls);
    issue_c     = 1'b0;
    issue_sel_c = win_c;
    if (!redir_if.STALL) begin
      if (state_q == ST_PENDING) begin
        issue_c     = 1'b1;
        issue_sel_c = higher_c ? win_c : held_q;
      end else if (win_c.cls != CLS_NONE) begin
        issue_c = 1'b1;
      end
    end
  end

  // FSM, held redirect and registered fetch controls.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      altpc_q <= '0;
      en_q    <= 1'b0;
      flush_q <= 1'b0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      en_q    <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (redir_if.STALL && (win_c.cls != CLS_NONE)) begin
            held_q  <= win_c;
            pend_q  <= 1'b1;
            state_q <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (redir_if.STALL) begin
            if (higher_c) begin
              held_q <= win_c;
            end
          end else begin
            pend_q  <= 1'b0;
            held_q  <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (issue_c) begin
        en_q    <= 1'b1;
        altpc_q <= issue_sel_c.target;
        flush_q <= (issue_sel_c.cls == CLS_EXC);
        mis_q   <= issue_sel_c.misalign;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign redir_if.AltPC_OUT         = altpc_q;
  assign redir_if.AltPCEnable_OUT   = en_q;
  assign redir_if.Flush_OUT         = flush_q;
  assign redir_if.Pending_OUT       = pend_q;
  assign redir_if.Misalign_OUT      = mis_q;
  assign redir_if.RedirectCount_OUT = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed vector table, reset/wrap sequences,
// and randomized traffic against a behavioural model.
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] EXC_V = 32'hBFC00380;

  logic CLOCK;
  logic RESET;

  fetch_redirect_ctrl_if #(.CNT_W(16)) bus ();

  fetch_redirect_ctrl #(
    .EXC_VECTOR (EXC_V),
    .CNT_W      (16)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .redir_if (bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: held redirect (if any), last target, issue count.
  logic        m_held_v;
  int          m_held_cls;
  logic [31:0] m_held_tgt;
  logic        m_held_mis;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        x_en, x_fl, x_mis;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jr;
    logic [31:0] jrt;
    logic        exc;
    logic        en;
    logic [31:0] pc;
    logic        fl;
    logic        pend;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic st, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                              logic e, logic en, logic [31:0] pc, logic fl, logic pd,
                              logic ms, logic [15:0] cn);
    vec_t v;
    v.stall = st; v.br = b; v.brt = bt; v.jr = j; v.jrt = jt; v.exc = e;
    v.en = en; v.pc = pc; v.fl = fl; v.pend = pd; v.mis = ms; v.cnt = cn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Winner by the priority rules: exception, then jump-register, then branch.
  task automatic winner(input logic b, input logic [31:0] bt, input logic j,
                        input logic [31:0] jt, input logic e,
                        output int cls, output logic [31:0] tgt, output logic mis);
    cls = 0; tgt = 32'h0; mis = 1'b0;
    if (e) begin
      cls = 3; tgt = EXC_V;
    end else if (j) begin
      if (jt % 4 != 0) begin cls = 3; tgt = EXC_V; mis = 1'b1; end
      else begin cls = 2; tgt = jt; end
    end else if (b) begin
      if (bt % 4 != 0) begin cls = 3; tgt = EXC_V; mis = 1'b1; end
      else begin cls = 1; tgt = bt; end
    end
  endtask

  task automatic model_reset();
    m_held_v = 1'b0; m_held_cls = 0; m_held_tgt = 32'h0; m_held_mis = 1'b0;
    m_pc = 32'h0; m_cnt = 16'h0; x_en = 1'b0; x_fl = 1'b0; x_mis = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt, input logic e);
    int cls; logic [31:0] tgt; logic mis;
    logic issued; int icls; logic [31:0] itgt; logic imis;
    winner(b, bt, j, jt, e, cls, tgt, mis);
    issued = 1'b0; icls = 0; itgt = 32'h0; imis = 1'b0;
    if (m_held_v) begin
      if (st) begin
        if (cls > m_held_cls) begin
          m_held_cls = cls; m_held_tgt = tgt; m_held_mis = mis;
        end
      end else begin
        issued = 1'b1;
        if (cls > m_held_cls) begin icls = cls; itgt = tgt; imis = mis; end
        else begin icls = m_held_cls; itgt = m_held_tgt; imis = m_held_mis; end
        m_held_v = 1'b0;
      end
    end else if (cls != 0) begin
      if (st) begin
        m_held_v = 1'b1; m_held_cls = cls; m_held_tgt = tgt; m_held_mis = mis;
      end else begin
        issued = 1'b1; icls = cls; itgt = tgt; imis = mis;
      end
    end
    x_en  = issued;
    x_fl  = issued && (icls == 3);
    x_mis = issued && imis;
    if (issued) begin
      m_pc  = itgt;
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample just after the edge.
  task automatic drive(input logic st, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic e);
    bus.STALL = st; bus.BrValid_IN = b; bus.BrTarget_IN = bt;
    bus.JrValid_IN = j; bus.JrTarget_IN = jt; bus.ExcValid_IN = e;
    model_step(st, b, bt, j, jt, e);
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    bus.STALL = 1'b0; bus.BrValid_IN = 1'b0; bus.BrTarget_IN = 32'h0;
    bus.JrValid_IN = 1'b0; bus.JrTarget_IN = 32'h0; bus.ExcValid_IN = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #2;
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " en"},   32'(bus.AltPCEnable_OUT),   32'(x_en));
    chk({tag, " pc"},   bus.AltPC_OUT,              m_pc);
    chk({tag, " fl"},   32'(bus.Flush_OUT),         32'(x_fl));
    chk({tag, " pend"}, 32'(bus.Pending_OUT),       32'(m_held_v));
    chk({tag, " mis"},  32'(bus.Misalign_OUT),      32'(x_mis));
    chk({tag, " cnt"},  32'(bus.RedirectCount_OUT), 32'(m_cnt));
  endtask

  initial begin
    // Directed cycle table, applied from reset in order.
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 16'd0);
    vecs[1]  = mk(0, 1, 32'hBFC00040, 0, 32'h0,        0, 1, 32'hBFC00040, 0, 0, 0, 16'd1);
    vecs[2]  = mk(0, 1, 32'hBFC00040, 1, 32'hBFC00100, 1, 1, EXC_V,        1, 0, 0, 16'd2);
    vecs[3]  = mk(1, 1, 32'hBFC00020, 0, 32'h0,        0, 0, EXC_V,        0, 1, 0, 16'd2);
    vecs[4]  = mk(1, 1, 32'hBFC00020, 1, 32'hBFC00200, 0, 0, EXC_V,        0, 1, 0, 16'd2);
    vecs[5]  = mk(1, 1, 32'hBFC00020, 0, 32'h0,        0, 0, EXC_V,        0, 1, 0, 16'd2);
    vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hBFC00200, 0, 0, 0, 16'd3);
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'hBFC00200, 0, 0, 0, 16'd3);
    vecs[8]  = mk(0, 0, 32'h0,        1, 32'hBFC00102, 0, 1, EXC_V,        1, 0, 1, 16'd4);
    vecs[9]  = mk(0, 1, 32'hBFC00010, 0, 32'h0,        0, 1, 32'hBFC00010, 0, 0, 0, 16'd5);
    vecs[10] = mk(0, 0, 32'h0,        1, 32'hBFC00020, 0, 1, 32'hBFC00020, 0, 0, 0, 16'd6);
    vecs[11] = mk(0, 1, 32'hBFC00001, 0, 32'h0,        0, 1, EXC_V,        1, 0, 1, 16'd7);
    vecs[12] = mk(1, 0, 32'h0,        1, 32'hBFC00300, 0, 0, EXC_V,        0, 1, 0, 16'd7);
    vecs[13] = mk(1, 1, 32'hBFC00400, 0, 32'h0,        0, 0, EXC_V,        0, 1, 0, 16'd7);
    vecs[14] = mk(0, 1, 32'hBFC00500, 0, 32'h0,        0, 1, 32'hBFC00300, 0, 0, 0, 16'd8);
    vecs[15] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'hBFC00300, 0, 1, 0, 16'd8);
    vecs[16] = mk(0, 0, 32'h0,        1, 32'hBFC00040, 0, 1, EXC_V,        1, 0, 0, 16'd9);

    do_reset();
    chk("reset en",   32'(bus.AltPCEnable_OUT),   32'h0);
    chk("reset pc",   bus.AltPC_OUT,              32'h0);
    chk("reset pend", 32'(bus.Pending_OUT),       32'h0);
    chk("reset cnt",  32'(bus.RedirectCount_OUT), 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].jr, vecs[i].jrt, vecs[i].exc);
      chk($sformatf("vec%0d en", i),   32'(bus.AltPCEnable_OUT),   32'(vecs[i].en));
      chk($sformatf("vec%0d pc", i),   bus.AltPC_OUT,              vecs[i].pc);
      chk($sformatf("vec%0d fl", i),   32'(bus.Flush_OUT),         32'(vecs[i].fl));
      chk($sformatf("vec%0d pend", i), 32'(bus.Pending_OUT),       32'(vecs[i].pend));
      chk($sformatf("vec%0d mis", i),  32'(bus.Misalign_OUT),      32'(vecs[i].mis));
      chk($sformatf("vec%0d cnt", i),  32'(bus.RedirectCount_OUT), 32'(vecs[i].cnt));
    end

    // Reset asserted while a redirect is held: everything clears, nothing issues later.
    do_reset();
    drive(0, 1, 32'hBFC00040, 0, 32'h0, 0);
    drive(1, 0, 32'h0, 1, 32'hBFC00200, 0);
    chk("pre-rst pend", 32'(bus.Pending_OUT), 32'h1);
    #2;
    RESET = 1'b0;
    #1;
    chk("midrst pend", 32'(bus.Pending_OUT),       32'h0);
    chk("midrst pc",   bus.AltPC_OUT,              32'h0);
    chk("midrst cnt",  32'(bus.RedirectCount_OUT), 32'h0);
    chk("midrst en",   32'(bus.AltPCEnable_OUT),   32'h0);
    #1;
    RESET = 1'b1;
    model_reset();
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    chk_model("postrst1");
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    chk_model("postrst2");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic st, b, j, e;
      logic [31:0] bt, jt, r;
      st = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 9) == 0);
      r  = $urandom();
      bt = ($urandom_range(0, 7) == 0) ? r : {r[31:2], 2'b00};
      r  = $urandom();
      jt = ($urandom_range(0, 7) == 0) ? r : {r[31:2], 2'b00};
      drive(st, b, bt, j, jt, e);
      chk_model($sformatf("rnd%0d", i));
    end

    // Counter wrap: 2^16-1 back-to-back redirects then one more.
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(0, 1, 32'hBFC00040, 0, 32'h0, 0);
    end
    chk("wrap allones", 32'(bus.RedirectCount_OUT), 32'h0000FFFF);
    chk("wrap b2b en",  32'(bus.AltPCEnable_OUT),   32'h1);
    drive(0, 0, 32'h0, 1, 32'hBFC00080, 0);
    chk("wrap zero",    32'(bus.RedirectCount_OUT), 32'h0);
    chk("wrap pc",      bus.AltPC_OUT,              32'hBFC00080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
